// File: rtl/sram_like_responder.sv
// Single-outstanding SRAM-like slave: accepts one request, optionally waits
// WAIT_CYCLES, performs one synchronous SRAM access, then returns data_ok.
module sram_like_responder #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        ram_en,
    output logic [3:0]  ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic [1:0]  state_dbg
);

    // Handshake: a request transfers on any cycle where req && addr_ok; the
    // initiator may drop or change req/fields afterwards. data_ok is a single
    // cycle pulse per accepted request and is never back-pressured.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  byte_mask;
    logic        accept;

    assign accept = req && addr_ok;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        wr_q    <= wr;
                        size_q  <= size;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= 4'(WAIT_CYCLES);
                        end else begin
                            state <= ACCESS;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                // cnt was loaded with WAIT_CYCLES, so leaving at 1 gives exactly that many WAIT cycles
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state <= ACCESS;
                        cnt   <= 4'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS:  state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        byte_mask = 4'b1111;
        case (size_q)
            2'd0:    byte_mask = 4'b0001 << addr_q[1:0];
            2'd1:    byte_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    end

    assign addr_ok   = resetn && ((state == IDLE) || (state == RESP));
    assign data_ok   = (state == RESP);
    // The SRAM returns read data the cycle after ram_en, which is exactly RESP.
    assign rdata     = ((state == RESP) && !wr_q) ? ram_rdata : 32'h0;
    assign ram_en    = (state == ACCESS);
    assign ram_wen   = (ram_en && wr_q) ? byte_mask : 4'b0000;
    assign ram_addr  = {addr_q[31:2], 2'b00};
    assign ram_wdata = wdata_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: one instance with no wait states and
// one with three, sharing a clock, reset and a behavioural SRAM.
`timescale 1ns/1ps
module tb_sram_like_responder;

    logic        clk;
    logic        resetn;

    logic        req_0, wr_0;
    logic [1:0]  size_0;
    logic [31:0] addr_0, wdata_0;
    logic        addr_ok_0, data_ok_0, ram_en_0;
    logic [31:0] rdata_0, ram_addr_0, ram_wdata_0, ram_rdata_0;
    logic [3:0]  ram_wen_0;
    logic [1:0]  state_dbg_0;

    logic        req_3, wr_3;
    logic [1:0]  size_3;
    logic [31:0] addr_3, wdata_3;
    logic        addr_ok_3, data_ok_3, ram_en_3;
    logic [31:0] rdata_3, ram_addr_3, ram_wdata_3, ram_rdata_3;
    logic [3:0]  ram_wen_3;
    logic [1:0]  state_dbg_3;

    logic [31:0] mem [logic [31:0]];

    int checks;
    int failures;

    sram_like_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .req(req_0), .wr(wr_0), .size(size_0),
        .addr(addr_0), .wdata(wdata_0), .addr_ok(addr_ok_0), .data_ok(data_ok_0),
        .rdata(rdata_0), .ram_en(ram_en_0), .ram_wen(ram_wen_0), .ram_addr(ram_addr_0),
        .ram_wdata(ram_wdata_0), .ram_rdata(ram_rdata_0), .state_dbg(state_dbg_0)
    );

    sram_like_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .resetn(resetn), .req(req_3), .wr(wr_3), .size(size_3),
        .addr(addr_3), .wdata(wdata_3), .addr_ok(addr_ok_3), .data_ok(data_ok_3),
        .rdata(rdata_3), .ram_en(ram_en_3), .ram_wen(ram_wen_3), .ram_addr(ram_addr_3),
        .ram_wdata(ram_wdata_3), .ram_rdata(ram_rdata_3), .state_dbg(state_dbg_3)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM model: read data appears the cycle after ram_en.
    always @(posedge clk) begin
        if (ram_en_0) ram_rdata_0 <= mem[ram_addr_0];
        if (ram_en_3) ram_rdata_3 <= mem[ram_addr_3];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        checks++; if (addr_ok_0 !== 1'b0) begin failures++; $display("FAIL rst_addr_ok0 got=%b exp=0", addr_ok_0); end
        checks++; if (addr_ok_3 !== 1'b0) begin failures++; $display("FAIL rst_addr_ok3 got=%b exp=0", addr_ok_3); end
        checks++; if (data_ok_0 !== 1'b0) begin failures++; $display("FAIL rst_data_ok0 got=%b exp=0", data_ok_0); end
        checks++; if (ram_en_0 !== 1'b0) begin failures++; $display("FAIL rst_ram_en0 got=%b exp=0", ram_en_0); end
        checks++; if (ram_wen_0 !== 4'b0) begin failures++; $display("FAIL rst_ram_wen0 got=%b exp=0000", ram_wen_0); end
        checks++; if (rdata_0 !== 32'h0) begin failures++; $display("FAIL rst_rdata0 got=%h exp=0", rdata_0); end
        checks++; if (state_dbg_0 !== 2'd0) begin failures++; $display("FAIL rst_state0 got=%0d exp=0", state_dbg_0); end
        tick();
        tick();
        checks++; if (ram_en_3 !== 1'b0) begin failures++; $display("FAIL rst_ram_en3 got=%b exp=0", ram_en_3); end
        checks++; if (data_ok_3 !== 1'b0) begin failures++; $display("FAIL rst_data_ok3 got=%b exp=0", data_ok_3); end
        resetn = 1'b1;
        #1;
        checks++; if (addr_ok_0 !== 1'b1) begin failures++; $display("FAIL rel_addr_ok0 got=%b exp=1", addr_ok_0); end
        checks++; if (addr_ok_3 !== 1'b1) begin failures++; $display("FAIL rel_addr_ok3 got=%b exp=1", addr_ok_3); end
        tick();
    endtask

    task automatic test_read_word();
        req_0 = 1'b1; wr_0 = 1'b0; size_0 = 2'd2; addr_0 = 32'h100; wdata_0 = 32'h0;
        #1;
        checks++; if (addr_ok_0 !== 1'b1) begin failures++; $display("FAIL rd_accept got=%b exp=1", addr_ok_0); end
        checks++; if (ram_en_0 !== 1'b0) begin failures++; $display("FAIL rd_en_early got=%b exp=0", ram_en_0); end
        tick();
        req_0 = 1'b0; addr_0 = 32'h3FC; wr_0 = 1'b1;
        #1;
        checks++; if (ram_en_0 !== 1'b1) begin failures++; $display("FAIL rd_ram_en got=%b exp=1", ram_en_0); end
        checks++; if (ram_addr_0 !== 32'h100) begin failures++; $display("FAIL rd_ram_addr got=%h exp=00000100", ram_addr_0); end
        checks++; if (ram_wen_0 !== 4'b0000) begin failures++; $display("FAIL rd_ram_wen got=%b exp=0000", ram_wen_0); end
        checks++; if (data_ok_0 !== 1'b0) begin failures++; $display("FAIL rd_data_ok_early got=%b exp=0", data_ok_0); end
        checks++; if (addr_ok_0 !== 1'b0) begin failures++; $display("FAIL rd_addr_ok_busy got=%b exp=0", addr_ok_0); end
        tick();
        checks++; if (data_ok_0 !== 1'b1) begin failures++; $display("FAIL rd_data_ok got=%b exp=1", data_ok_0); end
        checks++; if (rdata_0 !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_rdata got=%h exp=deadbeef", rdata_0); end
        tick();
        checks++; if (data_ok_0 !== 1'b0) begin failures++; $display("FAIL rd_data_ok_after got=%b exp=0", data_ok_0); end
        checks++; if (rdata_0 !== 32'h0) begin failures++; $display("FAIL rd_rdata_after got=%h exp=0", rdata_0); end
        checks++; if (addr_ok_0 !== 1'b1) begin failures++; $display("FAIL rd_idle_addr_ok got=%b exp=1", addr_ok_0); end
        wr_0 = 1'b0;
    endtask

    task automatic test_byte_write();
        req_0 = 1'b1; wr_0 = 1'b1; size_0 = 2'd0; addr_0 = 32'h103; wdata_0 = 32'hAB000000;
        tick();
        req_0 = 1'b0; wdata_0 = 32'h0; addr_0 = 32'h0;
        #1;
        checks++; if (ram_en_0 !== 1'b1) begin failures++; $display("FAIL bw_ram_en got=%b exp=1", ram_en_0); end
        checks++; if (ram_wen_0 !== 4'b1000) begin failures++; $display("FAIL bw_ram_wen got=%b exp=1000", ram_wen_0); end
        checks++; if (ram_addr_0 !== 32'h100) begin failures++; $display("FAIL bw_ram_addr got=%h exp=00000100", ram_addr_0); end
        checks++; if (ram_wdata_0 !== 32'hAB000000) begin failures++; $display("FAIL bw_ram_wdata got=%h exp=ab000000", ram_wdata_0); end
        tick();
        checks++; if (data_ok_0 !== 1'b1) begin failures++; $display("FAIL bw_data_ok got=%b exp=1", data_ok_0); end
        checks++; if (rdata_0 !== 32'h0) begin failures++; $display("FAIL bw_rdata got=%h exp=0", rdata_0); end
        tick();
        wr_0 = 1'b0;
    endtask

    task automatic test_halfword_wait();
        req_3 = 1'b1; wr_3 = 1'b1; size_3 = 2'd1; addr_3 = 32'h202; wdata_3 = 32'h12340000;
        #1;
        checks++; if (addr_ok_3 !== 1'b1) begin failures++; $display("FAIL hw_accept got=%b exp=1", addr_ok_3); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                req_3 = 1'b0; wdata_3 = 32'h0; addr_3 = 32'h0;
            end
            checks++; if (ram_en_3 !== (k == 4)) begin failures++; $display("FAIL hw_ram_en k=%0d got=%b exp=%b", k, ram_en_3, (k == 4)); end
            checks++; if (data_ok_3 !== (k == 5)) begin failures++; $display("FAIL hw_data_ok k=%0d got=%b exp=%b", k, data_ok_3, (k == 5)); end
            checks++; if (addr_ok_3 !== (k == 5)) begin failures++; $display("FAIL hw_addr_ok k=%0d got=%b exp=%b", k, addr_ok_3, (k == 5)); end
            if (k == 4) begin
                checks++; if (ram_wen_3 !== 4'b1100) begin failures++; $display("FAIL hw_ram_wen got=%b exp=1100", ram_wen_3); end
                checks++; if (ram_addr_3 !== 32'h200) begin failures++; $display("FAIL hw_ram_addr got=%h exp=00000200", ram_addr_3); end
                checks++; if (ram_wdata_3 !== 32'h12340000) begin failures++; $display("FAIL hw_ram_wdata got=%h exp=12340000", ram_wdata_3); end
            end else begin
                checks++; if (ram_wen_3 !== 4'b0000) begin failures++; $display("FAIL hw_wen_idle k=%0d got=%b exp=0000", k, ram_wen_3); end
            end
            if (k == 5) begin
                checks++; if (rdata_3 !== 32'h0) begin failures++; $display("FAIL hw_rdata got=%h exp=0", rdata_3); end
            end
        end
        tick();
        wr_3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        wr_0 = 1'b0; size_0 = 2'd2;
        for (int k = 0; k <= 8; k++) begin
            req_0  = (k < 8);
            addr_0 = (k % 2 == 0) ? 32'h100 : 32'h3FC;
            #1;
            checks++; if (addr_ok_0 !== (k % 2 == 0)) begin failures++; $display("FAIL b2b_addr_ok k=%0d got=%b exp=%b", k, addr_ok_0, (k % 2 == 0)); end
            checks++; if (data_ok_0 !== (k >= 2 && k % 2 == 0)) begin failures++; $display("FAIL b2b_data_ok k=%0d got=%b exp=%b", k, data_ok_0, (k >= 2 && k % 2 == 0)); end
            if (k % 2 == 1) begin
                checks++; if (ram_en_0 !== 1'b1) begin failures++; $display("FAIL b2b_ram_en k=%0d got=%b exp=1", k, ram_en_0); end
                checks++; if (ram_addr_0 !== 32'h100) begin failures++; $display("FAIL b2b_ram_addr k=%0d got=%h exp=00000100", k, ram_addr_0); end
            end
            if (k >= 2 && k % 2 == 0) begin
                checks++; if (rdata_0 !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_rdata k=%0d got=%h exp=deadbeef", k, rdata_0); end
            end
            if (req_0 && addr_ok_0) accepts++;
            tick();
        end
        req_0 = 1'b0;
        checks++; if (accepts !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", accepts); end
        checks++; if (state_dbg_0 !== 2'd0) begin failures++; $display("FAIL b2b_final_state got=%0d exp=0", state_dbg_0); end
    endtask

    task automatic test_reset_mid();
        req_3 = 1'b1; wr_3 = 1'b0; size_3 = 2'd2; addr_3 = 32'h100;
        tick();
        req_3 = 1'b0;
        #1;
        checks++; if (state_dbg_3 !== 2'd1) begin failures++; $display("FAIL rm_in_wait got=%0d exp=1", state_dbg_3); end
        tick();
        resetn = 1'b0;
        #1;
        checks++; if (addr_ok_3 !== 1'b0) begin failures++; $display("FAIL rm_addr_ok_in_rst got=%b exp=0", addr_ok_3); end
        checks++; if (state_dbg_3 !== 2'd0) begin failures++; $display("FAIL rm_state_in_rst got=%0d exp=0", state_dbg_3); end
        tick();
        resetn = 1'b1;
        #1;
        checks++; if (addr_ok_3 !== 1'b1) begin failures++; $display("FAIL rm_addr_ok_release got=%b exp=1", addr_ok_3); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (ram_en_3 !== 1'b0) begin failures++; $display("FAIL rm_ram_en k=%0d got=%b exp=0", k, ram_en_3); end
            checks++; if (data_ok_3 !== 1'b0) begin failures++; $display("FAIL rm_data_ok k=%0d got=%b exp=0", k, data_ok_3); end
            tick();
        end
    endtask

    task automatic test_size3();
        req_0 = 1'b1; wr_0 = 1'b0; size_0 = 2'd3; addr_0 = 32'h7;
        tick();
        req_0 = 1'b0; addr_0 = 32'h0;
        #1;
        checks++; if (ram_en_0 !== 1'b1) begin failures++; $display("FAIL s3_ram_en got=%b exp=1", ram_en_0); end
        checks++; if (ram_addr_0 !== 32'h4) begin failures++; $display("FAIL s3_ram_addr got=%h exp=00000004", ram_addr_0); end
        checks++; if (ram_wen_0 !== 4'b0000) begin failures++; $display("FAIL s3_ram_wen got=%b exp=0000", ram_wen_0); end
        tick();
        checks++; if (data_ok_0 !== 1'b1) begin failures++; $display("FAIL s3_data_ok got=%b exp=1", data_ok_0); end
        checks++; if (rdata_0 !== 32'h0BADF00D) begin failures++; $display("FAIL s3_rdata got=%h exp=0badf00d", rdata_0); end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        resetn = 1'b0;
        req_0 = 1'b0; wr_0 = 1'b0; size_0 = 2'd0; addr_0 = 32'h0; wdata_0 = 32'h0;
        req_3 = 1'b0; wr_3 = 1'b0; size_3 = 2'd0; addr_3 = 32'h0; wdata_3 = 32'h0;
        ram_rdata_0 = 32'h0;
        ram_rdata_3 = 32'h0;
        mem[32'h100] = 32'hDEADBEEF;
        mem[32'h004] = 32'h0BADF00D;
        mem[32'h200] = 32'h55AA55AA;

        test_reset();
        test_read_word();
        test_byte_write();
        test_halfword_wait();
        test_back_to_back();
        test_reset_mid();
        test_size3();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
